// File: rtl/sa_col_collector.sv
// rtl/sa_col_collector.sv - ping-pong burst collector for one systolic column result stream
// Optional build macro SA_COL_COLLECT_RELU_EN: negative words are stored as zero.
module sa_col_collector #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     col_valid,
    input  logic [DW-1:0]            col_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH)-1:0] out_index,
    output logic                     out_last,
    output logic                     ovf_err,
    output logic                     frag_err,
    input  logic                     clr_err
);
    localparam int            IW       = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_FILL = 2'd1,
        CAP_DROP = 2'd2
    } cap_state_e;

    cap_state_e    cap_q, cap_d;
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic          ovf_q, ovf_d;
    logic          frag_q, frag_d;
    logic [DW-1:0] mem_q [2][DEPTH];

    logic          wr_en, set_full, ovf_set, frag_set;
    logic          xfer, rel_bank, bank_free;
    logic [DW-1:0] wr_word;

`ifdef SA_COL_COLLECT_RELU_EN
    assign wr_word = col_result[DW-1] ? '0 : col_result;
`else
    assign wr_word = col_result;
`endif

    // The drain side is driven straight from the full flag so a completed
    // burst is visible the cycle after its last word is captured.
    assign out_valid = full_q[rd_bank_q];
    assign xfer      = out_valid & out_ready;
    assign rel_bank  = xfer & (rd_idx_q == LAST_IDX);
    assign out_data  = out_valid ? mem_q[rd_bank_q][rd_idx_q] : '0;
    assign out_index = rd_idx_q;
    assign out_last  = out_valid & (rd_idx_q == LAST_IDX);
    assign ovf_err   = ovf_q;
    assign frag_err  = frag_q;

    // A bank released by the drain this cycle may be refilled at once.
    assign bank_free = !full_q[wr_bank_q] || (rel_bank && (rd_bank_q == wr_bank_q));

    always_comb begin
        cap_d     = cap_q;
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        wr_en     = 1'b0;
        set_full  = 1'b0;
        ovf_set   = 1'b0;
        frag_set  = 1'b0;
        case (cap_q)
            CAP_IDLE: begin
                if (col_valid) begin
                    if (bank_free) begin
                        wr_en    = 1'b1;
                        wr_idx_d = IW'(1);
                        cap_d    = CAP_FILL;
                    end else begin
                        ovf_set = 1'b1;
                        cap_d   = CAP_DROP;
                    end
                end
            end
            CAP_FILL: begin
                if (col_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        set_full  = 1'b1;
                        wr_bank_d = ~wr_bank_q;
                        wr_idx_d  = '0;
                        cap_d     = CAP_IDLE;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end else begin
                    frag_set = 1'b1;
                    wr_idx_d = '0;
                    cap_d    = CAP_IDLE;
                end
            end
            CAP_DROP: begin
                if (!col_valid) cap_d = CAP_IDLE;
            end
            default: cap_d = CAP_IDLE;
        endcase
    end

    always_comb begin
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        if (xfer) begin
            if (rel_bank) begin
                rd_idx_d          = '0;
                rd_bank_d         = ~rd_bank_q;
                full_d[rd_bank_q] = 1'b0;
            end else begin
                rd_idx_d = rd_idx_q + IW'(1);
            end
        end
        if (set_full) full_d[wr_bank_q] = 1'b1;
        ovf_d  = clr_err ? 1'b0 : ovf_q;
        frag_d = clr_err ? 1'b0 : frag_q;
        if (ovf_set)  ovf_d  = 1'b1;
        if (frag_set) frag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q     <= CAP_IDLE;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            ovf_q     <= 1'b0;
            frag_q    <= 1'b0;
        end else begin
            cap_q     <= cap_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            ovf_q     <= ovf_d;
            frag_q    <= frag_d;
        end
    end

    // Storage needs no reset: contents are only observable behind a full flag.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_bank_q][wr_idx_q] <= wr_word;
    end

endmodule

// File: tb/tb_sa_col_collector.sv
// tb/tb_sa_col_collector.sv - self-checking bench for sa_col_collector
module tb_sa_col_collector;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam logic [31:0] NEG5 = 32'hFFFF_FFFB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          col_valid = 1'b0;
    logic [DW-1:0] col_result = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [3:0]    out_index;
    logic          out_last;
    logic          ovf_err;
    logic          frag_err;
    logic          clr_err = 1'b0;

    sa_col_collector #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .col_valid(col_valid), .col_result(col_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .ovf_err(ovf_err),
        .frag_err(frag_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef SA_COL_COLLECT_RELU_EN
        return w[31] ? 32'd0 : w;
`else
        return w;
`endif
    endfunction

    // Reference model: a capacity-two store of completed bursts, consumed word by word.
    logic [31:0] stq[$];
    logic [31:0] cur[$];
    int          m_bursts, m_rd, m_mode;
    bit          m_ovf, m_frag;

    logic        p_valid, p_ready, p_last, p_ok;
    logic [31:0] p_data;
    logic [3:0]  p_idx;

    task automatic model_reset();
        stq.delete(); cur.delete();
        m_bursts = 0; m_rd = 0; m_mode = 0; m_ovf = 0; m_frag = 0; p_ok = 0;
    endtask

    task automatic model_step(input logic cv, input logic [31:0] res, input logic rdy, input logic clr);
        bit ev;
        ev = (m_bursts > 0);
        if (ev && rdy) begin
            void'(stq.pop_front());
            if (m_rd == DEPTH - 1) begin m_rd = 0; m_bursts--; end
            else m_rd++;
        end
        if (clr) begin m_ovf = 0; m_frag = 0; end
        case (m_mode)
            0: if (cv) begin
                   if (m_bursts < 2) begin cur.delete(); cur.push_back(stored(res)); m_mode = 1; end
                   else begin m_ovf = 1; m_mode = 2; end
               end
            1: if (cv) begin
                   cur.push_back(stored(res));
                   if (cur.size() == DEPTH) begin
                       foreach (cur[k]) stq.push_back(cur[k]);
                       m_bursts++; m_mode = 0;
                   end
               end else begin
                   m_frag = 1; m_mode = 0;
               end
            default: if (!cv) m_mode = 0;
        endcase
    endtask

    task automatic apply(input logic cv, input logic [31:0] res, input logic rdy, input logic clr);
        col_valid = cv; col_result = res; out_ready = rdy; clr_err = clr;
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        bit ev;
        ev = (m_bursts > 0);
        chk("m_valid", 32'(out_valid), 32'(ev));
        chk("m_data", out_data, ev ? stq[0] : 32'd0);
        chk("m_index", 32'(out_index), 32'(m_rd));
        chk("m_last", 32'(out_last), 32'(ev && m_rd == DEPTH - 1));
        chk("m_ovf", 32'(ovf_err), 32'(m_ovf));
        chk("m_frag", 32'(frag_err), 32'(m_frag));
        if (p_ok && p_valid && !p_ready) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, p_data);
            chk("hold_index", 32'(out_index), 32'(p_idx));
            chk("hold_last", 32'(out_last), 32'(p_last));
        end
        p_valid = out_valid; p_ready = out_ready; p_data = out_data;
        p_idx = out_index; p_last = out_last; p_ok = 1;
        model_step(col_valid, col_result, out_ready, clr_err);
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic cv, input logic [31:0] res, input logic rdy, input logic clr);
        apply(cv, res, rdy, clr);
        finish_cycle();
    endtask

    task automatic burst(input int n, input logic [31:0] base, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b1, base + 32'(i), rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; col_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_frag", 32'(frag_err), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        cv;
        logic [31:0] res;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ei;
        logic        el;
        logic        eo;
        logic        ef;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic cv, input logic [31:0] res, input logic rdy, input logic clr,
                       input logic ev, input logic [31:0] ed, input int ei, input logic el,
                       input logic eo, input logic ef);
        vec_t v;
        v.cv = cv; v.res = res; v.rdy = rdy; v.clr = clr; v.ev = ev; v.ed = ed;
        v.ei = 4'(ei); v.el = el; v.eo = eo; v.ef = ef;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] relu_neg;
        int rem, gap, pr;
        bit fr;
        logic cv;

`ifdef SA_COL_COLLECT_RELU_EN
        relu_neg = 32'd0;
`else
        relu_neg = NEG5;
`endif
        // Single burst 1..16 with ready high, then idle.
        for (int i = 0; i < 16; i++) add(1, 32'(i + 1), 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 0, 1, 0, 1, 32'(i + 1), i, i == 15, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Alternating -5, 7 burst.
        for (int i = 0; i < 16; i++) add(1, (i % 2 == 0) ? NEG5 : 32'd7, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            add(0, 0, 1, 0, 1, (i % 2 == 0) ? relu_neg : 32'd7, i, i == 15, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // 9-word fragment, then a full burst, then clear.
        for (int i = 0; i < 9; i++) add(1, 32'(50 + i), 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(1, 32'(201 + i), 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) add(0, 0, 1, 0, 1, 32'(201 + i), i, i == 15, 0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        do_reset();

        foreach (tbl[n]) begin
            apply(tbl[n].cv, tbl[n].res, tbl[n].rdy, tbl[n].clr);
            chk("t_valid", 32'(out_valid), 32'(tbl[n].ev));
            chk("t_data", out_data, tbl[n].ed);
            chk("t_index", 32'(out_index), 32'(tbl[n].ei));
            chk("t_last", 32'(out_last), 32'(tbl[n].el));
            chk("t_ovf", 32'(ovf_err), 32'(tbl[n].eo));
            chk("t_frag", 32'(frag_err), 32'(tbl[n].ef));
            finish_cycle();
        end

        // Two back-to-back bursts held off, then drained.
        burst(16, 1, 1'b0);
        burst(16, 101, 1'b0);
        chk("b2b_valid_waiting", 32'(out_valid), 32'd1);
        chk("b2b_first_word", out_data, 32'd1);
        repeat (34) drive(1'b0, 0, 1'b1, 1'b0);
        chk("b2b_no_ovf", 32'(ovf_err), 32'd0);

        // Third back-to-back burst has no bank.
        burst(16, 1, 1'b0);
        burst(16, 101, 1'b0);
        drive(1'b1, 201, 1'b0, 1'b0);
        chk("drop_ovf_set", 32'(ovf_err), 32'd1);
        burst(15, 202, 1'b0);
        repeat (34) drive(1'b0, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b1);
        chk("drop_ovf_clr", 32'(ovf_err), 32'd0);

        // Ready toggling every cycle during drain.
        burst(16, 301, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b0, 0, 1'(i % 2), 1'b0);
        chk("toggle_done", 32'(out_valid), 32'd0);

        // Reset in the middle of a drain.
        burst(16, 401, 1'b1);
        repeat (5) drive(1'b0, 0, 1'b1, 1'b0);
        chk("pre_rst_index", 32'(out_index), 32'd5);
        do_reset();
        repeat (20) drive(1'b0, 0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        rem = 0; gap = 0; fr = 0; pr = 100;
        for (int c = 0; c < 4000; c++) begin
            if (c % 300 == 0) pr = (c / 300 % 3 == 0) ? 100 : ((c / 300 % 3 == 1) ? 20 : 60);
            cv = 1'b0;
            if (gap > 0) gap--;
            else begin
                if (rem == 0) begin
                    rem = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : 16;
                    fr = (rem < 16);
                end
                cv = 1'b1;
                rem--;
                if (rem == 0) gap = fr ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
            end
            drive(cv, $urandom, 1'($urandom_range(0, 99) < pr), 1'($urandom_range(0, 49) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sa_col_collector.md
# sa_col_collector

Receiver for the serialized result stream of a 16-PE systolic column. Captures each 16-word burst presented on the column's result/valid pair into a ping-pong buffer, then drains it to a downstream consumer over a valid/ready handshake with row index and last flag. Sits directly after the column, one instance per column, between the array and the output write-back logic.

## Interface
- DEPTH, 16, words per burst (rows per column); power of two
- DW, 32, result word width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- col_valid  input  1  result qualifier from column; high for exactly DEPTH consecutive cycles per burst
- col_result  input  DW  result word, row 1 first
- out_valid  output  1  drain word available
- out_ready  input  1  downstream accepts word
- out_data  output  DW  drained word
- out_index  output  log2(DEPTH)  row index of out_data, 0 = row 1
- out_last  output  1  high with index DEPTH-1
- ovf_err  output  1  sticky: burst dropped, no free bank
- frag_err  output  1  sticky: burst shorter than DEPTH, discarded
- clr_err  input  1  synchronous clear of both sticky errors

## Operation
- Two banks of DEPTH x DW registers, per-bank full flag, wr_bank/rd_bank pointers, wr_idx/rd_idx counters.
- Capture FSM: IDLE, FILL, DROP.
  - IDLE: col_valid rising with bank[wr_bank] free (or freed this cycle) -> write word at index 0, wr_idx=1, FILL; if bank full -> DROP, set ovf_err.
  - FILL: each col_valid cycle writes bank[wr_bank][wr_idx], wr_idx++. On write of index DEPTH-1: set full[wr_bank], toggle wr_bank, wr_idx=0, IDLE. col_valid low before DEPTH words: discard (no full flag), wr_idx=0, set frag_err, IDLE.
  - DROP: ignore words until col_valid low, then IDLE. Bank never marked.
- Drain FSM: IDLE, DRAIN. full[rd_bank] -> DRAIN, out_valid=1, out_data=bank[rd_bank][rd_idx], out_index=rd_idx. Transfer on out_valid&out_ready: rd_idx++. Transfer with out_last: clear full[rd_bank], toggle rd_bank, rd_idx=0; stay DRAIN if other bank full, else IDLE.
- out_data/out_index/out_last stable while out_valid&!out_ready.
- Simultaneous release and capture start on same bank: release wins, burst accepted.
- clr_err and same-cycle error set: set wins.
- Reset values: out_valid 0, out_data 0, out_index 0, out_last 0, ovf_err 0, frag_err 0; both banks empty, pointers and counters 0, both FSMs IDLE. Reset mid-burst or mid-drain discards all buffered data.

## Timing
- Capture: word sampled on the edge where col_valid=1; zero-bubble.
- Last word of burst sampled on edge T -> out_valid high after edge T (first cycle after T+0), i.e. 1-cycle latency, provided drain IDLE.
- Back-to-back bursts with no gap are accepted while one bank is free; with out_ready held high the drain sustains 1 word/cycle and never overflows.
- Errors assert the cycle after detection edge.

## Configuration
- SA_COL_COLLECT_RELU_EN defined: captured word stored as 0 when col_result is negative (signed MSB set), else unchanged.
- Undefined: words stored verbatim. No other behaviour differs.

## Test plan
- Single burst col_result=1..16, out_ready=1 -> out_data 1..16, out_index 0..15, out_last on 16, out_valid high exactly 16 cycles starting one cycle after last capture.
- Two back-to-back bursts (1..16, 101..116), out_ready=0 until both captured -> both drained in order, no ovf_err.
- Three back-to-back bursts, out_ready=0 -> third dropped, ovf_err=1 after its first word; first two drain intact; clr_err clears ovf_err.
- Burst of 9 words then col_valid low -> frag_err=1, no out_valid; following full burst drains correctly from index 0.
- out_ready toggled 1/0 every cycle during drain -> each word held stable while stalled, all 16 delivered in order.
- SA_COL_COLLECT_RELU_EN defined, col_result=-5,7 pattern -> out_data 0,7; undefined -> 0xFFFFFFFB,7. Reset asserted mid-drain -> out_valid 0 immediately, no residual words after release.
